// File: rtl/bcd_disp_pkg.sv
// ---------------------------------------------------------------------------
// bcd_disp_pkg
// Shared constants for the multiplexed 4-digit seven-segment display driver.
//   - DIV_DEFAULT     : default clock cycles per digit slot
//   - SEG_*           : active-low segment patterns, bit order {g,f,e,d,c,b,a}
//   - slot_t          : digit slot index (0 = least significant digit)
//   - slot_enable()   : active-low one-cold digit enable for a slot
// ---------------------------------------------------------------------------
package bcd_disp_pkg;

   localparam int DIV_DEFAULT = 50000;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_DASH  = 7'h3F;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef logic [1:0] slot_t;

   function automatic logic [3:0] slot_enable(input slot_t s);
      return ~(4'b0001 << s);
   endfunction

endpackage

// File: rtl/bcd_to_sseg.sv
// ---------------------------------------------------------------------------
// bcd_to_sseg
// Combinational BCD to seven-segment decoder (active-low segments).
//   bcd : in  4  digit value; 10..15 are shown as a dash
//   seg : out 7  segment pattern {g,f,e,d,c,b,a}, 0 = segment lit
// ---------------------------------------------------------------------------
module bcd_to_sseg
   import bcd_disp_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_DASH;
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/bcd_disp_mux.sv
// ---------------------------------------------------------------------------
// bcd_disp_mux
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// Digits are snapshotted once per frame so a digit never tears mid-scan,
// leading zeros can be blanked, and all display outputs are registered.
//   clk            : in  1  system clock
//   rst            : in  1  asynchronous reset, active-low
//   d3,d2,d1,d0    : in  4  BCD digits, d3 most significant
//   dp_in          : in  4  decimal-point request, bit i for digit i
//   an             : out 4  digit enables, active-low one-cold
//   sseg           : out 8  segments, active-low {dp,g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
module bcd_disp_mux
   import bcd_disp_pkg::*;
#(
   parameter int DIV      = DIV_DEFAULT,
   parameter bit BLANK_LZ = 1'b1
)(
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] d3,
   input  logic [3:0] d2,
   input  logic [3:0] d1,
   input  logic [3:0] d0,
   input  logic [3:0] dp_in,
   output logic [3:0] an,
   output logic [7:0] sseg
);

   localparam int PW = $clog2(DIV);

   logic [PW-1:0] prescaler;
   slot_t         slot;
   logic [3:0]    digit_shadow [4];
   logic [3:0]    dp_shadow;
   logic          load_pending;

   logic [3:0]    d_in [4];
   logic          tc;
   logic          frame_load;
   logic [3:1]    lead_zero;
   logic          blank;
   logic [3:0]    cur_digit;
   logic [6:0]    cur_seg;

   assign d_in[0] = d0;
   assign d_in[1] = d1;
   assign d_in[2] = d2;
   assign d_in[3] = d3;

   assign tc = (prescaler == PW'(DIV - 1));
   // Snapshot right out of reset, then only as slot 3 hands over to slot 0.
   assign frame_load = load_pending | (tc & (slot == 2'd3));

   // lead_zero[i]: shadow digits i..3 are all zero.
   assign lead_zero[3] = (digit_shadow[3] == 4'd0);
   generate
      for (genvar gi = 1; gi < 3; gi++) begin : g_lz
         assign lead_zero[gi] = lead_zero[gi+1] & (digit_shadow[gi] == 4'd0);
      end
   endgenerate

   always_comb begin
      blank = 1'b0;
      case (slot)
         2'd1:    blank = lead_zero[1];
         2'd2:    blank = lead_zero[2];
         2'd3:    blank = lead_zero[3];
         default: blank = 1'b0;   // units digit is always shown
      endcase
      if (!BLANK_LZ) blank = 1'b0;
   end

   assign cur_digit = digit_shadow[slot];

   bcd_to_sseg u_dec (
      .bcd (cur_digit),
      .seg (cur_seg)
   );

   // Scan timing and digit snapshot.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prescaler    <= '0;
         slot         <= 2'd0;
         dp_shadow    <= 4'd0;
         load_pending <= 1'b1;
         for (int i = 0; i < 4; i++) digit_shadow[i] <= 4'd0;
      end else begin
         load_pending <= 1'b0;
         prescaler    <= tc ? '0 : prescaler + PW'(1);
         if (tc) slot <= slot + 2'd1;
         if (frame_load) begin
            dp_shadow <= dp_in;
            for (int i = 0; i < 4; i++) digit_shadow[i] <= d_in[i];
         end
      end
   end

   // Registered display outputs. While the first snapshot is still pending
   // the display stays dark, so the first lit digit already shows real data.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         an   <= 4'hF;
         sseg <= 8'hFF;
      end else if (load_pending) begin
         an   <= 4'hF;
         sseg <= 8'hFF;
      end else begin
         an   <= slot_enable(slot);
         sseg <= {~dp_shadow[slot], (blank ? SEG_BLANK : cur_seg)};
      end
   end

endmodule

// File: tb/tb_bcd_disp_mux.sv
// ---------------------------------------------------------------------------
// tb_bcd_disp_mux
// Self-checking bench for bcd_disp_mux with DIV=4. One instance has
// leading-zero blanking enabled, a second has it disabled; both share inputs.
// ---------------------------------------------------------------------------
module tb_bcd_disp_mux;

   localparam int DIV = 4;

   logic       clk;
   logic       rst;
   logic [3:0] d3, d2, d1, d0;
   logic [3:0] dp_in;
   logic [3:0] an, an_nb;
   logic [7:0] sseg, sseg_nb;

   int checks = 0;
   int errors = 0;

   bcd_disp_mux #(.DIV(DIV), .BLANK_LZ(1'b1)) dut (
      .clk (clk), .rst (rst),
      .d3 (d3), .d2 (d2), .d1 (d1), .d0 (d0),
      .dp_in (dp_in), .an (an), .sseg (sseg)
   );

   bcd_disp_mux #(.DIV(DIV), .BLANK_LZ(1'b0)) dut_nb (
      .clk (clk), .rst (rst),
      .d3 (d3), .d2 (d2), .d1 (d1), .d0 (d0),
      .dp_in (dp_in), .an (an_nb), .sseg (sseg_nb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model + scoreboard ----------------
   typedef struct {
      logic [3:0] an;
      logic [7:0] sseg;
      logic [7:0] sseg_nb;
   } exp_t;

   exp_t       sb [$];
   int         m_cnt;
   int         m_slot;
   logic [3:0] m_sh [4];
   logic [3:0] m_dp;
   bit         m_lp;

   function automatic logic [6:0] ref_seg(input logic [3:0] v);
      case (v)
         4'd0: return 7'h40;  4'd1: return 7'h79;
         4'd2: return 7'h24;  4'd3: return 7'h30;
         4'd4: return 7'h19;  4'd5: return 7'h12;
         4'd6: return 7'h02;  4'd7: return 7'h78;
         4'd8: return 7'h00;  4'd9: return 7'h10;
         default: return 7'h3F;
      endcase
   endfunction

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %h want %h at %0t", name, got, want, $time);
      end
   endtask

   // Predict the outputs of the coming edge, advance the model, clock, compare.
   task automatic step();
      exp_t       e;
      logic [3:0] one;
      bit         bl;
      logic [6:0] sg;
      one = 4'b0001;
      if (!rst) begin
         e = '{an: 4'hF, sseg: 8'hFF, sseg_nb: 8'hFF};
         m_cnt = 0; m_slot = 0; m_dp = 4'd0; m_lp = 1'b1;
         for (int j = 0; j < 4; j++) m_sh[j] = 4'd0;
      end else begin
         if (m_lp) begin
            e = '{an: 4'hF, sseg: 8'hFF, sseg_nb: 8'hFF};
         end else begin
            bl = (m_slot != 0);
            for (int j = 0; j < 4; j++)
               if (j >= m_slot && m_sh[j] != 4'd0) bl = 1'b0;
            sg        = ref_seg(m_sh[m_slot]);
            e.an      = ~(one << m_slot);
            e.sseg    = {~m_dp[m_slot], (bl ? 7'h7F : sg)};
            e.sseg_nb = {~m_dp[m_slot], sg};
         end
         if (m_lp || (m_cnt == DIV - 1 && m_slot == 3)) begin
            m_sh[0] = d0; m_sh[1] = d1; m_sh[2] = d2; m_sh[3] = d3;
            m_dp = dp_in;
         end
         m_lp = 1'b0;
         if (m_cnt == DIV - 1) begin
            m_cnt  = 0;
            m_slot = (m_slot + 1) % 4;
         end else begin
            m_cnt++;
         end
      end
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check("sb_an",      {4'h0, an},    {4'h0, e.an});
      check("sb_sseg",    sseg,          e.sseg);
      check("sb_sseg_nb", sseg_nb,       e.sseg_nb);
      check("sb_an_nb",   {4'h0, an_nb}, {4'h0, e.an});
   endtask

   // ---------------- table-driven vectors ----------------
   typedef struct packed {
      logic [15:0] d;     // {d3,d2,d1,d0}
      logic [3:0]  dp;
      logic [31:0] exp;   // sseg per slot {s3,s2,s1,s0}, blanking on
   } vec_t;

   vec_t tbl [9];

   initial begin
      int idx;
      int waited;
      bit found;
      logic [31:0] ex;

      tbl[0] = '{d: 16'h1234, dp: 4'b0000, exp: 32'hF9A4B099};
      tbl[1] = '{d: 16'h0007, dp: 4'b0000, exp: 32'hFFFFFFF8};
      tbl[2] = '{d: 16'h0507, dp: 4'b0000, exp: 32'hFF92C0F8};
      tbl[3] = '{d: 16'h12C4, dp: 4'b0000, exp: 32'hF9A4BF99};
      tbl[4] = '{d: 16'h1234, dp: 4'b0100, exp: 32'hF924B099};
      tbl[5] = '{d: 16'h8060, dp: 4'b0001, exp: 32'h80C08240};
      tbl[6] = '{d: 16'h0000, dp: 4'b1000, exp: 32'h7FFFFFC0};
      tbl[7] = '{d: 16'h00F0, dp: 4'b0000, exp: 32'hFFFFBFC0};
      tbl[8] = '{d: 16'h9000, dp: 4'b0000, exp: 32'h90C0C0C0};

      rst = 1'b0;
      {d3, d2, d1, d0} = 16'h1234;
      dp_in = 4'b0000;

      // Reset held for 5 cycles: dark display throughout.
      repeat (5) step();
      check("rst_an", {4'h0, an}, 8'h0F);
      check("rst_sseg", sseg, 8'hFF);

      // Release away from the edge; d0 shown two edges later.
      rst = 1'b1;
      step();
      step();
      check("rel_an", {4'h0, an}, 8'h0E);
      check("rel_sseg", sseg, 8'h99);

      // Table vectors: hold each for 3 frames, check the last frame by slot.
      for (int i = 0; i < 9; i++) begin
         {d3, d2, d1, d0} = tbl[i].d;
         dp_in = tbl[i].dp;
         ex = tbl[i].exp;
         for (int c = 0; c < 48; c++) begin
            step();
            if (c >= 32) begin
               case (an)
                  4'b1110: idx = 0;
                  4'b1101: idx = 1;
                  4'b1011: idx = 2;
                  4'b0111: idx = 3;
                  default: idx = -1;
               endcase
               if (idx < 0) begin
                  check("tbl_an_onecold", {4'h0, an}, 8'h0E);
               end else begin
                  check($sformatf("tbl%0d_slot%0d", i, idx), sseg, ex[idx*8 +: 8]);
               end
            end
         end
      end

      // Snapshot: change d0 during slot 2; next frame's slot 0 shows 9.
      {d3, d2, d1, d0} = 16'h1234;
      dp_in = 4'b0000;
      repeat (40) step();
      waited = 0;
      while (m_slot != 2 && waited < 20) begin step(); waited++; end
      check("snap_sync", {7'h0, m_slot == 2}, 8'h01);
      d0 = 4'd9;
      found = 1'b0;
      for (int c = 0; c < 40 && !found; c++) begin
         step();
         if (an == 4'b1110) begin
            found = 1'b1;
            check("snap_d0", sseg, 8'h90);
         end
      end
      if (!found) check("snap_timeout", 8'h00, 8'h01);

      // Asynchronous reset mid-scan during slot 2.
      waited = 0;
      while (m_slot != 2 && waited < 20) begin step(); waited++; end
      check("ares_sync", {7'h0, m_slot == 2}, 8'h01);
      #3;
      rst = 1'b0;
      #1;
      check("ares_an",      {4'h0, an}, 8'h0F);
      check("ares_sseg",    sseg,       8'hFF);
      check("ares_sseg_nb", sseg_nb,    8'hFF);
      step();
      step();
      rst = 1'b1;
      step();
      step();
      check("ares_restart_an", {4'h0, an}, 8'h0E);
      check("ares_restart_sseg", sseg, 8'h90);
      repeat (20) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
